d_output_arbiter: RTL and testbench
===================================

# d_output_arbiter

Downstream stage of the transmission-layer logic. It drains the two destination FIFOs (D0, D1) through their pop/empty interface and merges them into a single 6-bit output stream with a valid/ready handshake. Service is round-robin between the two FIFOs, gated by the FSM's `active_out`. A 2-entry output buffer absorbs the FIFOs' one-cycle read latency, and per-destination counters track words delivered.

## Interface
- `DATA_WIDTH`, 6, word width; same as FIFO `data_out`.
- `COUNT_WIDTH`, 5, width of each delivered-word counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `active_in`  in  1  FSM `active_out`; pops are allowed only while this is 1.
- `empty_D0`, `empty_D1`  in  1  FIFO empty flags.
- `data_D0`, `data_D1`  in  DATA_WIDTH  FIFO read data; valid the cycle after the pop.
- `D0_pop`, `D1_pop`  out  1  FIFO pop strobes; combinational; at most one is high per cycle.
- `ready_in`  in  1  downstream accepts `data_out` this cycle.
- `valid_out`  out  1  `data_out`/`dest_out` hold a word.
- `data_out`  out  DATA_WIDTH  head-of-buffer word.
- `dest_out`  out  1  source of the head word: 0 = D0, 1 = D1.
- `count_D0`, `count_D1`  out  COUNT_WIDTH  words delivered per source; saturating.
- `busy`  out  1  buffer non-empty or a pop is in flight.

## Operation
- **Reset values.** While `reset` is 1, at the next edge:
  - `valid_out`, `data_out`, `dest_out`, `count_D0`, `count_D1`, `busy` = 0.
  - Buffer emptied; in-flight flag cleared; last-grant pointer = D1, so D0 wins first.
  - `D0_pop`/`D1_pop` are forced to 0 combinationally during reset.
- **Space.** `space = 2 - occ - inflight + (valid_out & ready_in)`.
  - `occ` ∈ {0,1,2} is the buffer occupancy.
  - `inflight` is 1 if a pop was issued the previous cycle.
- **Pop eligibility.** Source x is eligible when `active_in` = 1, `empty_Dx` = 0, `space` ≥ 1 and not in reset.
- **Arbitration.**
  - Only one source eligible: pop it.
  - Both eligible: pop the one not granted last.
  - The last-grant pointer updates only when a pop issues.
- **Capture.** The cycle after a pop, the FIFO `data_Dx` plus its source tag are written into the buffer tail.
- **Output.** The buffer is a FIFO of depth 2.
  - The head drives `data_out`/`dest_out`; `valid_out` = (`occ` > 0).
  - A transfer occurs when `valid_out & ready_in`; the head then advances.
  - Capture and transfer may happen in the same cycle.
  - With `occ` = 0 and a capture, the word appears at the head the next cycle (no bypass).
- **Stable output.** While `valid_out` = 1 and `ready_in` = 0, `data_out`/`dest_out` must not change.
- **Counters.** On each transfer, `count_D0` or `count_D1` (selected by `dest_out`) increments by 1 and saturates at 2^COUNT_WIDTH−1. Reset is the only clear.
- **`active_in` falls mid-stream.**
  - No new pops.
  - An in-flight word is still captured.
  - The buffer continues draining to `ready_in`.
- **`reset` mid-stream.** Buffer and in-flight word are discarded; counters clear.
- **Overflow/underflow.** The space rule guarantees the buffer never overflows. Popping an empty FIFO is illegal and never occurs.
- **`busy`.** `busy` = (`occ` > 0) | `inflight`.

## Timing
- Pop in cycle t → word on `data_Dx` in t+1 → captured at the end of t+1 → `valid_out` = 1 in t+2. Latency from pop to `valid_out` is 2 cycles.
- Sustained throughput with `ready_in` = 1 and a non-empty source: 1 word/cycle. `Dx_pop` combinationally depends on `ready_in`.
- With `ready_in` stuck at 0: at most 2 pops are issued, then the pops stop until a transfer.
- Counter update is visible the cycle after the transfer edge.

## Test plan
- **Reset.** Hold `reset` = 1 with both FIFOs non-empty and `active_in` = 1.
  - Required: no pops; all outputs 0.
  - After release: `D0_pop` goes high in the first cycle.
- **Single source streaming.** D0 holds 0x05, 0x14, 0x06; D1 empty; `ready_in` = 1.
  - Required: pops on 3 consecutive cycles.
  - `data_out` = 0x05, 0x14, 0x06 on consecutive cycles, starting 2 cycles after the first pop.
  - `dest_out` = 0; `count_D0` = 3.
- **Both sources non-empty.** D0 = {0x05, 0x0E}, D1 = {0x16, 0x22}.
  - Required output order: 0x05/0, 0x16/1, 0x0E/0, 0x22/1.
  - `count_D0` = `count_D1` = 2.
- **Back-pressure.** `ready_in` = 0 while D0 holds 5 words.
  - Required: exactly 2 pops, then `valid_out` held with stable data.
  - Release `ready_in`: all 5 words delivered in order with no loss or duplication.
- **`active_in` drop and reset mid-transfer.**
  - Drop `active_in` the cycle after a pop: that word is still delivered and no further pops occur.
  - Assert `reset` with `occ` = 2: the next cycle shows `valid_out` = 0 and counts = 0.
- **Counter saturation.** Deliver 40 D1 words.
  - Required: `count_D1` stops at 31; `count_D0` stays 0.

Source files
------------

// File: rtl/d_output_arbiter.sv
// Round-robin drain of the two destination FIFOs into one valid/ready output stream.
// A 2-entry buffer absorbs the FIFO read latency; per-source counters track delivered words.
module d_output_arbiter #(
    parameter int DATA_WIDTH  = 6,
    parameter int COUNT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   active_in,
    input  logic                   empty_D0,
    input  logic                   empty_D1,
    input  logic [DATA_WIDTH-1:0]  data_D0,
    input  logic [DATA_WIDTH-1:0]  data_D1,
    output logic                   D0_pop,
    output logic                   D1_pop,
    input  logic                   ready_in,
    output logic                   valid_out,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   dest_out,
    output logic [COUNT_WIDTH-1:0] count_D0,
    output logic [COUNT_WIDTH-1:0] count_D1,
    output logic                   busy
);

    logic [DATA_WIDTH-1:0] head_data, tail_data;
    logic                  head_dest, tail_dest;
    logic [1:0]            occ;
    logic                  inflight;
    logic                  inflight_src;
    logic                  last_grant;
    logic                  xfer;
    logic [2:0]            space;
    logic                  can_pop;
    logic [DATA_WIDTH-1:0] cap_data;

    assign valid_out = (occ != 2'd0);
    assign xfer      = valid_out & ready_in;
    assign data_out  = head_data;
    assign dest_out  = head_dest;
    assign busy      = valid_out | inflight;
    assign cap_data  = inflight_src ? data_D1 : data_D0;

    // occ + inflight never exceeds 2, so this cannot wrap below zero
    assign space   = 3'd2 + {2'b00, xfer} - {1'b0, occ} - {2'b00, inflight};
    assign can_pop = ~reset & active_in & (space != 3'd0);

    // last_grant = 1 means D1 was served last, so D0 wins a tie
    always_comb begin
        D0_pop = 1'b0;
        D1_pop = 1'b0;
        if (can_pop) begin
            if (!empty_D0 && (empty_D1 || last_grant)) begin
                D0_pop = 1'b1;
            end else if (!empty_D1) begin
                D1_pop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_data    <= '0;
            tail_data    <= '0;
            head_dest    <= 1'b0;
            tail_dest    <= 1'b0;
            occ          <= 2'd0;
            inflight     <= 1'b0;
            inflight_src <= 1'b0;
            last_grant   <= 1'b1;
            count_D0     <= '0;
            count_D1     <= '0;
        end else begin
            inflight <= D0_pop | D1_pop;
            if (D0_pop || D1_pop) begin
                inflight_src <= D1_pop;
                last_grant   <= D1_pop;
            end

            case (occ)
                2'd0: begin
                    if (inflight) begin
                        head_data <= cap_data;
                        head_dest <= inflight_src;
                        occ       <= 2'd1;
                    end
                end
                2'd1: begin
                    if (xfer && inflight) begin
                        head_data <= cap_data;
                        head_dest <= inflight_src;
                    end else if (xfer) begin
                        occ <= 2'd0;
                    end else if (inflight) begin
                        tail_data <= cap_data;
                        tail_dest <= inflight_src;
                        occ       <= 2'd2;
                    end
                end
                default: begin
                    if (xfer) begin
                        head_data <= tail_data;
                        head_dest <= tail_dest;
                        if (inflight) begin
                            tail_data <= cap_data;
                            tail_dest <= inflight_src;
                        end else begin
                            occ <= 2'd1;
                        end
                    end
                end
            endcase

            if (xfer) begin
                if (head_dest) begin
                    if (count_D1 != '1) count_D1 <= count_D1 + COUNT_WIDTH'(1);
                end else begin
                    if (count_D0 != '1) count_D0 <= count_D0 + COUNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_d_output_arbiter.sv
// Bench for d_output_arbiter: behavioural FIFO/scoreboard model, directed steps then random traffic.
module tb_d_output_arbiter;

    logic       clk = 1'b0;
    logic       reset, active_in, empty_D0, empty_D1, ready_in;
    logic [5:0] data_D0, data_D1;
    logic       D0_pop, D1_pop, valid_out, dest_out, busy;
    logic [5:0] data_out;
    logic [4:0] count_D0, count_D1;

    d_output_arbiter #(.DATA_WIDTH(6), .COUNT_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .active_in(active_in),
        .empty_D0(empty_D0), .empty_D1(empty_D1),
        .data_D0(data_D0), .data_D1(data_D1),
        .D0_pop(D0_pop), .D1_pop(D1_pop), .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .dest_out(dest_out),
        .count_D0(count_D0), .count_D1(count_D1), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] data;
        logic       dest;
        int         rdy;
    } ent_t;

    logic [5:0] q0[$], q1[$];
    ent_t       pend[$];
    logic [6:0] log_q[$];
    int         cyc, npops, first_pop_cyc, first_out_cyc, last_pop_cyc;
    int         m_cnt0, m_cnt1;
    bit         m_last;
    bit         s_pop0, s_valid;
    int         n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh_empty();
        empty_D0 = (q0.size() == 0);
        empty_D1 = (q1.size() == 0);
    endtask

    task automatic cycle();
        bit   vexp, xf, can, e0, e1;
        ent_t e;
        @(negedge clk);
        vexp = (pend.size() > 0) && (pend[0].rdy <= cyc);
        xf   = vexp && ready_in;
        check("valid_out", valid_out, vexp);
        if (vexp) begin
            check("data_out", data_out, pend[0].data);
            check("dest_out", dest_out, pend[0].dest);
        end
        check("busy", busy, pend.size() > 0);
        check("count_D0", count_D0, m_cnt0);
        check("count_D1", count_D1, m_cnt1);
        can = !reset && active_in && ((int'(pend.size()) - int'(xf)) <= 1);
        e0  = can && (q0.size() > 0) && ((q1.size() == 0) || m_last);
        e1  = can && (q1.size() > 0) && ((q0.size() == 0) || !m_last);
        check("D0_pop", D0_pop, e0);
        check("D1_pop", D1_pop, e1);
        s_pop0  = D0_pop;
        s_valid = valid_out;
        if (valid_out && ready_in) begin
            if (log_q.size() == 0) first_out_cyc = cyc;
            log_q.push_back({dest_out, data_out});
        end
        @(posedge clk);
        #1;
        if (reset) begin
            pend.delete();
            m_cnt0 = 0;
            m_cnt1 = 0;
            m_last = 1'b1;
        end else begin
            if (xf) begin
                e = pend.pop_front();
                if (e.dest) m_cnt1 = (m_cnt1 == 31) ? 31 : m_cnt1 + 1;
                else        m_cnt0 = (m_cnt0 == 31) ? 31 : m_cnt0 + 1;
            end
            if (e0 || e1) begin
                if (npops == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                npops++;
                m_last = e1;
            end
            if (e0) begin
                data_D0 = q0.pop_front();
                pend.push_back('{data: data_D0, dest: 1'b0, rdy: cyc + 2});
            end else if (e1) begin
                data_D1 = q1.pop_front();
                pend.push_back('{data: data_D1, dest: 1'b1, rdy: cyc + 2});
            end
        end
        cyc++;
        refresh_empty();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        q0.delete();
        q1.delete();
        refresh_empty();
        log_q.delete();
        npops = 0;
    endtask

    initial begin
        reset = 1'b1; active_in = 1'b1; ready_in = 1'b1;
        data_D0 = '0; data_D1 = '0;
        cyc = 0; npops = 0; m_cnt0 = 0; m_cnt1 = 0; m_last = 1'b1;
        first_pop_cyc = 0; first_out_cyc = 0; last_pop_cyc = 0;

        // reset held with both sources non-empty
        q0 = '{6'h01, 6'h02};
        q1 = '{6'h03};
        refresh_empty();
        run(3);
        check("rst_data_out", data_out, 0);
        check("rst_dest_out", dest_out, 0);
        reset = 1'b0;
        cycle();
        check("rst_first_pop_D0", s_pop0, 1);
        run(6);

        // single source streaming
        do_reset();
        q0 = '{6'h05, 6'h14, 6'h06};
        refresh_empty();
        run(8);
        check("ss_npops", npops, 3);
        check("ss_consecutive", last_pop_cyc - first_pop_cyc, 2);
        check("ss_latency", first_out_cyc - first_pop_cyc, 2);
        check("ss_len", log_q.size(), 3);
        if (log_q.size() == 3) begin
            check("ss_w0", log_q[0], {1'b0, 6'h05});
            check("ss_w1", log_q[1], {1'b0, 6'h14});
            check("ss_w2", log_q[2], {1'b0, 6'h06});
        end
        check("ss_count_D0", count_D0, 3);

        // both sources: alternating order
        do_reset();
        q0 = '{6'h05, 6'h0E};
        q1 = '{6'h16, 6'h22};
        refresh_empty();
        run(9);
        check("rr_len", log_q.size(), 4);
        if (log_q.size() == 4) begin
            check("rr_w0", log_q[0], {1'b0, 6'h05});
            check("rr_w1", log_q[1], {1'b1, 6'h16});
            check("rr_w2", log_q[2], {1'b0, 6'h0E});
            check("rr_w3", log_q[3], {1'b1, 6'h22});
        end
        check("rr_count_D0", count_D0, 2);
        check("rr_count_D1", count_D1, 2);

        // back-pressure
        do_reset();
        ready_in = 1'b0;
        q0 = '{6'h11, 6'h22, 6'h33, 6'h04, 6'h15};
        refresh_empty();
        run(8);
        check("bp_npops", npops, 2);
        check("bp_valid_held", s_valid, 1);
        ready_in = 1'b1;
        run(10);
        check("bp_len", log_q.size(), 5);
        if (log_q.size() == 5) begin
            check("bp_w0", log_q[0], {1'b0, 6'h11});
            check("bp_w4", log_q[4], {1'b0, 6'h15});
        end

        // active_in drops the cycle after a pop
        do_reset();
        q0 = '{6'h2A, 6'h2B, 6'h2C};
        refresh_empty();
        cycle();
        active_in = 1'b0;
        run(6);
        check("act_npops", npops, 1);
        check("act_len", log_q.size(), 1);
        if (log_q.size() == 1) check("act_w0", log_q[0], {1'b0, 6'h2A});

        // reset with a full buffer
        do_reset();
        active_in = 1'b1;
        ready_in = 1'b0;
        q0 = '{6'h31, 6'h32, 6'h33};
        refresh_empty();
        run(4);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        active_in = 1'b0;
        cycle();
        check("midrst_valid", s_valid, 0);
        check("midrst_count_D0", count_D0, 0);
        check("midrst_count_D1", count_D1, 0);

        // counter saturation
        active_in = 1'b1;
        ready_in = 1'b1;
        do_reset();
        for (int i = 0; i < 40; i++) q1.push_back(6'($urandom_range(0, 63)));
        refresh_empty();
        run(48);
        check("sat_count_D1", count_D1, 31);
        check("sat_count_D0", count_D0, 0);
        check("sat_len", log_q.size(), 40);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            active_in = ($urandom_range(0, 9) != 0);
            ready_in  = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 2) == 0) q0.push_back(6'($urandom_range(0, 63)));
            if ($urandom_range(0, 2) == 0) q1.push_back(6'($urandom_range(0, 63)));
            if (q0.size() > 8) q0.delete();
            if (q1.size() > 8) q1.delete();
            refresh_empty();
            cycle();
        end
        reset = 1'b0;
        run(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
